// File: rtl/swd_pkg.sv
// Shared constants, state encoding and parity helper for the SWD transfer master.
// A frame is 48 bits: request, turnaround, ACK, data and parity.
package swd_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam int FRAME_BITS = 48;

    // Bit positions inside the 48-bit frame
    localparam int REQ_FIRST  = 3;
    localparam int TRN_BIT    = 11;
    localparam int ACK_FIRST  = 12;
    localparam int DATA_FIRST = 15;
    localparam int PAR_BIT    = 47;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_FRAME,
        ST_EVAL,
        ST_RESP
    } state_t;

    // Odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [31:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/swd_sck_gen.sv
// Bit-period divider: sck is low for the first CLK_DIV cycles of a period and high
// for the second CLK_DIV cycles. Strobes mark period start, sck rise and period end.
import swd_pkg::*;

module swd_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck_level,
    output logic bit_start,
    output logic sck_rise,
    output logic bit_end
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Counter parks at zero while disabled so every enable begins on a period start
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_start = en && (cnt == '0);
    assign sck_rise  = en && (cnt == HALF);
    assign bit_end   = en && (cnt == LAST);
    assign sck_level = en && (cnt >= HALF);

endmodule

// File: rtl/swd_xfer_master.sv
// Command-level SWD transfer sequencer: serialises one request/data frame per attempt,
// captures ACK/read data/parity, retries on WAIT and returns a one-cycle response.
import swd_pkg::*;

module swd_xfer_master #(
    parameter int CLK_DIV        = 1,
    parameter int GAP_BITS       = 4,
    parameter int WAIT_RETRY_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_req,
    input  logic        cmd_rnw,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_parity_err,
    output logic [3:0]  rsp_retries,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        fe_rst_n,
    output logic        fe_rnw
);

    localparam logic [15:0] B_REQ  = 16'(REQ_FIRST);
    localparam logic [15:0] B_TRN  = 16'(TRN_BIT);
    localparam logic [15:0] B_ACK  = 16'(ACK_FIRST);
    localparam logic [15:0] B_DATA = 16'(DATA_FIRST);
    localparam logic [15:0] B_PAR  = 16'(PAR_BIT);
    localparam logic [15:0] B_LAST = 16'(FRAME_BITS - 1);
    localparam logic [15:0] B_GAP  = 16'(GAP_BITS - 1);

    state_t      state, state_next;
    logic [7:0]  req_q;
    logic [31:0] wdata_q;
    logic [15:0] bit_cnt;
    logic [2:0]  ack_q;
    logic [31:0] rdata_q;
    logic        par_q;
    logic [3:0]  retries_q;

    logic sck_en, sck_level, bit_start, sck_rise, bit_end;
    logic accept, gap_done, frame_done, retry, frame_bit;

    swd_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (sck_en),
        .sck_level (sck_level),
        .bit_start (bit_start),
        .sck_rise  (sck_rise),
        .bit_end   (bit_end)
    );

    assign sck_en     = (state == ST_GAP) || (state == ST_FRAME);
    assign accept     = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign gap_done   = (state == ST_GAP) && bit_end && (bit_cnt == B_GAP);
    assign frame_done = (state == ST_FRAME) && bit_end && (bit_cnt == B_LAST);
    assign retry      = (state == ST_EVAL) && (ack_q == ACK_WAIT)
                        && (retries_q < 4'(WAIT_RETRY_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept)     state_next = ST_GAP;
            ST_GAP:   if (gap_done)   state_next = ST_FRAME;
            ST_FRAME: if (frame_done) state_next = ST_EVAL;
            ST_EVAL:  state_next = retry ? ST_GAP : ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Wire value of the current frame bit; reads send zeros after the request
    always_comb begin
        frame_bit = 1'b0;
        if (bit_cnt >= B_REQ && bit_cnt < B_TRN) begin
            frame_bit = req_q[3'(bit_cnt - B_REQ)];
        end else if (!fe_rnw && bit_cnt >= B_DATA && bit_cnt < B_PAR) begin
            frame_bit = wdata_q[5'(bit_cnt - B_DATA)];
        end else if (!fe_rnw && bit_cnt == B_PAR) begin
            frame_bit = odd_parity(wdata_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            wdata_q   <= '0;
            fe_rnw    <= 1'b0;
            retries_q <= '0;
            bit_cnt   <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            if (accept) begin
                req_q     <= cmd_req;
                wdata_q   <= cmd_wdata;
                fe_rnw    <= cmd_rnw;
                retries_q <= '0;
            end else if (retry) begin
                retries_q <= retries_q + 4'd1;
            end

            // One counter serves both phases; it restarts at each phase boundary
            if (!sck_en || gap_done || frame_done) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 16'd1;
            end

            if (state == ST_FRAME && sck_rise) begin
                if (bit_cnt >= B_ACK && bit_cnt < B_DATA) begin
                    ack_q[2'(bit_cnt - B_ACK)] <= miso;
                end else if (bit_cnt >= B_DATA && bit_cnt < B_PAR) begin
                    rdata_q[5'(bit_cnt - B_DATA)] <= miso;
                end else if (bit_cnt == B_PAR) begin
                    par_q <= miso;
                end
            end
        end
    end

    // Registered outputs: the wire sees each state one cycle after the FSM enters it
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready      <= 1'b0;
            sck            <= 1'b0;
            mosi           <= 1'b0;
            fe_rst_n       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_ack        <= '0;
            rsp_rdata      <= '0;
            rsp_parity_err <= 1'b0;
            rsp_retries    <= '0;
        end else begin
            cmd_ready <= (state_next == ST_IDLE);
            sck       <= sck_level;
            fe_rst_n  <= (state == ST_FRAME);
            if (state != ST_FRAME) begin
                mosi <= 1'b0;
            end else if (bit_start) begin
                mosi <= frame_bit;
            end

            rsp_valid <= (state == ST_RESP);
            if (state == ST_RESP) begin
                rsp_ack        <= ack_q;
                rsp_retries    <= retries_q;
                rsp_rdata      <= (fe_rnw && ack_q == ACK_OK) ? rdata_q : '0;
                rsp_parity_err <= fe_rnw && (ack_q == ACK_OK)
                                  && (par_q != odd_parity(rdata_q));
            end
        end
    end

endmodule

// File: tb/tb_swd_xfer_master.sv
// Directed bench for swd_xfer_master: a miso model plays the target, records each
// frame seen on mosi, and a scoreboard checks every response and its timing.
module tb_swd_xfer_master;
    import swd_pkg::*;

    localparam int CLK_DIV        = 1;
    localparam int GAP_BITS       = 4;
    localparam int WAIT_RETRY_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_req = '0;
    logic        cmd_rnw = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_parity_err;
    logic [3:0]  rsp_retries;
    logic        sck, mosi, fe_rst_n, fe_rnw;
    logic        miso = 1'b0;

    swd_xfer_master #(
        .CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS), .WAIT_RETRY_MAX(WAIT_RETRY_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_req(cmd_req),
        .cmd_rnw(cmd_rnw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata),
        .rsp_parity_err(rsp_parity_err), .rsp_retries(rsp_retries),
        .sck(sck), .mosi(mosi), .miso(miso), .fe_rst_n(fe_rst_n), .fe_rnw(fe_rnw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic        perr;
        logic [3:0]  retries;
        int          latency;
        int          frames;
        logic [47:0] frame;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    time  accept_time = 0;

    // Target model configuration (written by the stimulus, read by the model)
    int          cfg_wait = 0;
    logic [2:0]  cfg_ack = 3'b001;
    logic [31:0] cfg_data = '0;
    logic        cfg_par_flip = 1'b0;
    int          cfg_base = 0;

    // Target model state
    int          frame_cnt = 0;
    int          k = 0;
    int          gap_rises = 0;
    int          gap_errs = 0;
    int          mosi_gap_errs = 0;
    int          rsp_pulses = 0;
    logic [47:0] cur_frame = '0;
    logic [47:0] last_frame = '0;
    logic [2:0]  cur_ack = '0;
    logic        prev_sck = 1'b0;
    logic        prev_fe = 1'b0;

    function automatic logic model_bit(input int idx);
        if (idx >= 12 && idx <= 14) return cur_ack[idx-12];
        if (idx >= 15 && idx <= 46) return cfg_data[idx-15];
        if (idx == 47) return (~^cfg_data) ^ cfg_par_flip;
        return 1'b0;
    endfunction

    // Next miso bit is presented right after the sck rise that captured the previous one
    always @(negedge clk) begin
        if (fe_rst_n && !prev_fe) begin
            frame_cnt++;
            if (gap_rises != GAP_BITS) gap_errs++;
            gap_rises = 0;
            k = 0;
            cur_ack = ((frame_cnt - cfg_base) <= cfg_wait) ? 3'b010 : cfg_ack;
        end
        if (!fe_rst_n && prev_fe) begin
            if (k == 48) last_frame = cur_frame;
            gap_rises = 0;
            k = 0;
        end
        if (!fe_rst_n) begin
            if (sck && !prev_sck) gap_rises++;
            if (mosi) mosi_gap_errs++;
        end else if (sck && !prev_sck) begin
            if (k < 48) cur_frame[k] = mosi;
            k++;
        end
        miso = fe_rst_n ? model_bit(k) : 1'b0;
        if (rsp_valid) rsp_pulses++;
        prev_sck = sck;
        prev_fe  = fe_rst_n;
    end

    function automatic logic [47:0] exp_frame(input logic [7:0] req, input logic rnw,
                                               input logic [31:0] wdata);
        logic [47:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[3+i] = req[i];
        if (!rnw) begin
            for (int i = 0; i < 32; i++) f[15+i] = wdata[i];
            f[47] = ~^wdata;
        end
        return f;
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] ack, input logic [31:0] rdata,
                                    input logic perr, input int retries, input logic [47:0] frame);
        exp_t e;
        e.ack     = ack;
        e.rdata   = rdata;
        e.perr    = perr;
        e.retries = 4'(retries);
        e.frames  = retries + 1;
        e.latency = (retries + 1) * ((GAP_BITS + 48) * 2 * CLK_DIV + 1) + 1;
        e.frame   = frame;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] req, input logic rnw, input logic [31:0] wdata,
                        input exp_t e);
        sb.push_back(e);
        cfg_base = frame_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_req   = req;
        cmd_rnw   = rnw;
        cmd_wdata = wdata;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        check("accept_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        accept_time = $time;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_ready", 64'(cmd_ready), 64'd0);
        check("fe_rnw", 64'(fe_rnw), 64'(rnw));
    endtask

    task automatic wait_rsp(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check({tag, "_rsp_seen"}, 64'(seen), 64'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_ack"}, 64'(rsp_ack), 64'(e.ack));
            check({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            check({tag, "_perr"}, 64'(rsp_parity_err), 64'(e.perr));
            check({tag, "_retries"}, 64'(rsp_retries), 64'(e.retries));
            check({tag, "_latency"}, 64'(($time - 5 - accept_time) / 10), 64'(e.latency));
            check({tag, "_frames"}, 64'(frame_cnt - cfg_base), 64'(e.frames));
            check({tag, "_frame"}, 64'(last_frame), 64'(e.frame));
            check({tag, "_gap_errs"}, 64'(gap_errs), 64'd0);
            check({tag, "_gap_mosi"}, 64'(mosi_gap_errs), 64'd0);
            @(negedge clk);
            check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
            check({tag, "_held_ack"}, 64'(rsp_ack), 64'(e.ack));
        end
    endtask

    initial begin
        int pulses_before;
        bit hit;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_outs", {59'd0, rsp_valid, sck, mosi, fe_rst_n, fe_rnw}, 64'd0);
        check("rst_rsp", {rsp_ack, rsp_rdata, rsp_parity_err, rsp_retries}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready), 64'd1);

        // Write with ACK OK
        cfg_wait = 0; cfg_ack = 3'b001; cfg_data = 32'h0; cfg_par_flip = 1'b0;
        send(8'hA5, 1'b0, 32'hA55A_3C5C,
             mk_exp(3'b001, 32'h0, 1'b0, 0, exp_frame(8'hA5, 1'b0, 32'hA55A_3C5C)));
        wait_rsp("wr_ok");

        // Read with good parity
        cfg_data = 32'h1234_5678;
        send(8'h8D, 1'b1, 32'hFFFF_FFFF,
             mk_exp(3'b001, 32'h1234_5678, 1'b0, 0, exp_frame(8'h8D, 1'b1, 32'h0)));
        wait_rsp("rd_ok");

        // Read with inverted parity
        cfg_par_flip = 1'b1;
        send(8'h8D, 1'b1, 32'h0,
             mk_exp(3'b001, 32'h1234_5678, 1'b1, 0, exp_frame(8'h8D, 1'b1, 32'h0)));
        wait_rsp("rd_perr");
        cfg_par_flip = 1'b0;

        // Two WAITs then OK
        cfg_wait = 2;
        send(8'hB1, 1'b0, 32'h0F0F_1234,
             mk_exp(3'b001, 32'h0, 1'b0, 2, exp_frame(8'hB1, 1'b0, 32'h0F0F_1234)));
        wait_rsp("wait2");

        // Persistent WAIT exhausts the retry budget
        cfg_wait = 100;
        send(8'h9F, 1'b1, 32'h0,
             mk_exp(3'b010, 32'h0, 1'b0, WAIT_RETRY_MAX, exp_frame(8'h9F, 1'b1, 32'h0)));
        wait_rsp("wait_max");

        // FAULT: single frame, no retry
        cfg_wait = 0; cfg_ack = 3'b100;
        send(8'hA3, 1'b0, 32'hDEAD_BEEF,
             mk_exp(3'b100, 32'h0, 1'b0, 0, exp_frame(8'hA3, 1'b0, 32'hDEAD_BEEF)));
        wait_rsp("fault");

        // Invalid ACK on a read: no data, no parity error
        cfg_ack = 3'b111;
        send(8'h87, 1'b1, 32'h0,
             mk_exp(3'b111, 32'h0, 1'b0, 0, exp_frame(8'h87, 1'b1, 32'h0)));
        wait_rsp("ack_inv");

        // Reset at frame bit 20 drops the command
        cfg_ack = 3'b001;
        send(8'hA5, 1'b0, 32'h5555_AAAA,
             mk_exp(3'b001, 32'h0, 1'b0, 0, exp_frame(8'hA5, 1'b0, 32'h5555_AAAA)));
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (fe_rst_n && k == 20 && !sck) hit = 1'b1;
        end
        check("reach_bit20", 64'(hit), 64'd1);
        pulses_before = rsp_pulses;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", {59'd0, sck, mosi, fe_rst_n, cmd_ready, rsp_valid}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(cmd_ready), 64'd1);
        send(8'hB5, 1'b0, 32'hC0FF_EE01,
             mk_exp(3'b001, 32'h0, 1'b0, 0, exp_frame(8'hB5, 1'b0, 32'hC0FF_EE01)));
        wait_rsp("after_rst");
        check("midrst_pulses", 64'(rsp_pulses - pulses_before), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/swd_xfer_master.md
Name: swd_xfer_master

Overview:
Command-level SWD transfer sequencer that sits directly upstream of swd_frontend_top. It accepts one transfer command (request byte, direction, write data) on a valid/ready handshake. It then generates the SPI-side 48-bit frame (sck, mosi, fe_rst_n, fe_rnw) that the frontend consumes, and captures ACK, read data and parity from miso. It retries automatically on WAIT and returns a one-cycle response pulse.

Parameters:
CLK_DIV, 1, sck half-period in clk cycles (>=1)
GAP_BITS, 4, sck periods with fe_rst_n low before every frame attempt (>=1)
WAIT_RETRY_MAX, 8, maximum automatic re-issues after a WAIT ACK (0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  master idle, command accepted when cmd_valid&&cmd_ready
cmd_req  input  8  SWD request byte, sent LSB first
cmd_rnw  input  1  1=read, 0=write
cmd_wdata  input  32  write data, sent LSB first
rsp_valid  output  1  one-cycle response strobe, no backpressure
rsp_ack  output  3  received ACK, rsp_ack[0]=first ACK bit on wire
rsp_rdata  output  32  read data (0 unless read with ACK OK)
rsp_parity_err  output  1  read parity mismatch (read with ACK OK only)
rsp_retries  output  4  number of WAIT re-issues performed
sck  output  1  SPI clock to frontend
mosi  output  1  serial frame to frontend
miso  input  1  serial return from frontend
fe_rst_n  output  1  frontend frame reset, low between frames
fe_rnw  output  1  direction to frontend, latched from cmd_rnw

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_ack=0, rsp_rdata=0, rsp_parity_err=0, rsp_retries=0, sck=0, mosi=0, fe_rst_n=0, fe_rnw=0. cmd_ready rises the first cycle after rst deasserts.
- rst mid-transfer: next edge forces all outputs to reset values. The command is dropped and no rsp_valid is issued.
- States: IDLE -> GAP -> FRAME -> EVAL -> (GAP on retry | RESP) -> IDLE.
- IDLE: cmd_ready=1, sck=0, fe_rst_n=0. On accept, latch req/rnw/wdata, clear retry count, go to GAP.
- Bit period = 2*CLK_DIV clk cycles. sck is low for the first half and high for the second half. mosi changes only at a bit-period start. miso is sampled on the clk cycle where sck rises.
- GAP: GAP_BITS periods with fe_rst_n=0, mosi=0, sck toggling. fe_rst_n goes 1 at the start of bit 0 of FRAME.
- FRAME bit index k=0..47 on mosi:
  - 0-2: 0.
  - 3-10: req[k-3].
  - 11: 0 (turnaround).
  - 12-14: 0.
  - 15-46: wdata[k-15] for writes, 0 for reads.
  - 47: write parity = ~^wdata (odd), 0 for reads.
- Capture from miso: ACK bit k-12 at k=12..14; read data bit k-15 at k=15..46; read parity at k=47.
- Write data is always shifted; gating on ACK is the frontend's job.
- EVAL (1 cycle, fe_rst_n=0, sck=0):
  - If ack==3'b010 and retries<WAIT_RETRY_MAX: increment retries, go to GAP.
  - Otherwise go to RESP.
- RESP (1 cycle): rsp_valid=1 with all rsp_* fields stable. The fields hold until the next accept.
  - rsp_parity_err = (captured parity != ~^rdata), only when read and ack==3'b001.
  - rsp_rdata=0 when write or ACK not OK.
- Latency: rsp_valid is asserted exactly (retries+1)*((GAP_BITS+48)*2*CLK_DIV+1)+1 cycles after the accept edge. With defaults and no retry this is 106.
- cmd_valid while busy is ignored, because cmd_ready=0. No command queueing.
- ACK values other than 001/010 (FAULT 100, or invalid such as 111 or 000) go straight to RESP with no retry.

Decomposition:
- Package swd_pkg holds:
  - ACK_OK=3'b001, ACK_WAIT=3'b010, ACK_FAULT=3'b100.
  - FRAME_BITS=48.
  - Bit-index constants REQ_FIRST=3, TRN_BIT=11, ACK_FIRST=12, DATA_FIRST=15, PAR_BIT=47.
  - Odd-parity function.
- Sub-module swd_sck_gen: a divider generating sck plus one-cycle bit_start and sck_rise strobes from CLK_DIV, enabled by the master FSM.

Test Plan:
- Write, req=8'hA5, wdata=32'hA55A_3C5C, miso model returns ACK 001 -> mosi bits 3-10 = A5 LSB-first, bits 15-46 = A55A3C5C, bit 47 = ~^wdata; rsp_ack=001, retries=0, parity_err=0, rsp_valid at accept+106.
- Read, model returns ACK 001, data 32'h1234_5678, parity ~^data -> rsp_rdata=12345678, parity_err=0; mosi is 0 in bits 15-47.
- Read, same data with parity bit inverted -> rsp_rdata=12345678, parity_err=1.
- ACK WAIT on the first two attempts, then OK -> three frames each preceded by 4 GAP periods with fe_rst_n low; rsp_retries=2, rsp_ack=001.
- Persistent WAIT -> exactly 9 frames; rsp_ack=010, rsp_retries=8, rsp_rdata=0. Repeat with ACK 100: single frame, rsp_ack=100.
- rst asserted at FRAME bit 20 -> next cycle sck=0, mosi=0, fe_rst_n=0, cmd_ready=0, no rsp_valid. After release, cmd_ready=1 and a new write completes normally.
